// File: rtl/riego_multicanal.sv
// riego_multicanal: multi-channel irrigation controller.
// Each channel keeps a hysteretic "needs water" flag built from decoded humidity samples.
// A round-robin arbiter runs at most one pump at a time. Each run is limited by a
// max-on timeout, and a mandatory all-off cooldown follows every run.
// Ports:
//   clk, rst         system clock, synchronous active-high reset
//   sample_valid     1-cycle strobe qualifying sample_ch / sample_hum / plant_type
//   sample_ch        channel of the sample (values >= NCH are ignored)
//   sample_hum       humidity reading, larger = wetter
//   plant_type       selects the start threshold for this sample
//   pump_present     per-channel pump module detect
//   fault_clr        1-cycle strobe clearing all sticky timeout faults
//   pump_en          registered pump drive, one-hot or zero
//   fault            sticky per-channel timeout fault
//   alarm            registered OR of fault
//   busy             registered, high while the FSM is in RUN or COOL
module riego_multicanal #(
  parameter int unsigned NCH         = 4,
  parameter int unsigned HUM_W       = 12,
  parameter int unsigned TICK_DIV    = 50000,
  parameter int unsigned MAX_ON_MS   = 10000,
  parameter int unsigned COOLDOWN_MS = 30000,
  parameter int unsigned HYST        = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sample_valid,
  input  logic [$clog2(NCH)-1:0]  sample_ch,
  input  logic [HUM_W-1:0]        sample_hum,
  input  logic [3:0]              plant_type,
  input  logic [NCH-1:0]          pump_present,
  input  logic                    fault_clr,
  output logic [NCH-1:0]          pump_en,
  output logic [NCH-1:0]          fault,
  output logic                    alarm,
  output logic                    busy
);

  localparam int unsigned CHW    = $clog2(NCH);
  localparam int unsigned PW     = $clog2(TICK_DIV + 1);
  localparam int unsigned MS_MAX = (MAX_ON_MS > COOLDOWN_MS) ? MAX_ON_MS : COOLDOWN_MS;
  localparam int unsigned MSW    = $clog2(MS_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_COOL} state_t;

  state_t           state, state_nxt;
  logic [CHW-1:0]   cur, cur_nxt, rr, rr_nxt, pick;
  logic [NCH-1:0]   need, need_nxt, fault_nxt, fault_set, pump_nxt, eligible;
  logic [PW-1:0]    presc;
  logic [MSW-1:0]   ms_cnt;
  logic             tick, found, ch_ok;
  logic [HUM_W-1:0] thr, stop;
  logic [HUM_W:0]   stop_sum;

  // Start threshold per plant type
  always_comb begin
    case (plant_type)
      4'd0:    thr = HUM_W'(12'h200);
      4'd1:    thr = HUM_W'(12'h600);
      4'd2:    thr = HUM_W'(12'h900);
      default: thr = HUM_W'(12'h700);
    endcase
  end

  // Stop threshold saturates at full scale instead of wrapping
  assign stop_sum = {1'b0, thr} + (HUM_W+1)'(HYST);
  assign stop     = stop_sum[HUM_W] ? '1 : stop_sum[HUM_W-1:0];

  assign ch_ok    = 32'(sample_ch) < NCH;
  assign tick     = (presc == PW'(TICK_DIV - 1));
  assign eligible = need & pump_present & ~fault;

  // Hysteretic need update; readings between the thresholds keep the old flag
  always_comb begin
    need_nxt = need;
    if (sample_valid && ch_ok) begin
      if (sample_hum < thr)
        need_nxt[sample_ch] = 1'b1;
      else if (sample_hum >= stop)
        need_nxt[sample_ch] = 1'b0;
    end
  end

  // Round-robin pick: first eligible channel after the last granted one
  always_comb begin
    pick  = rr;
    found = 1'b0;
    for (int unsigned k = 1; k <= NCH; k++) begin
      int unsigned j;
      j = 32'(rr) + k;
      if (j >= NCH) j = j - NCH;
      if (!found && eligible[CHW'(j)]) begin
        found = 1'b1;
        pick  = CHW'(j);
      end
    end
  end

  // Next-state and registered-output decode
  always_comb begin
    state_nxt = state;
    cur_nxt   = cur;
    rr_nxt    = rr;
    fault_set = '0;
    case (state)
      S_IDLE: begin
        if (found) begin
          state_nxt = S_RUN;
          cur_nxt   = pick;
          rr_nxt    = pick;
        end
      end
      S_RUN: begin
        // Pump loss and a satisfied channel both outrank the timeout
        if (!pump_present[cur] || !need_nxt[cur]) begin
          state_nxt = S_COOL;
        end else if (ms_cnt == MSW'(MAX_ON_MS)) begin
          fault_set[cur] = 1'b1;
          state_nxt      = S_COOL;
        end
      end
      S_COOL: begin
        if (ms_cnt == MSW'(COOLDOWN_MS))
          state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    fault_nxt = (fault & ~{NCH{fault_clr}}) | fault_set;
    pump_nxt  = '0;
    if (state_nxt == S_RUN)
      pump_nxt[cur_nxt] = 1'b1;
  end

  // State, datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cur     <= '0;
      rr      <= CHW'(NCH - 1);
      need    <= '0;
      fault   <= '0;
      pump_en <= '0;
      alarm   <= 1'b0;
      busy    <= 1'b0;
      presc   <= '0;
      ms_cnt  <= '0;
    end else begin
      state   <= state_nxt;
      cur     <= cur_nxt;
      rr      <= rr_nxt;
      need    <= need_nxt;
      fault   <= fault_nxt;
      pump_en <= pump_nxt;
      alarm   <= |fault;
      busy    <= (state != S_IDLE);
      presc   <= tick ? '0 : presc + PW'(1);
      if (state_nxt != state)
        ms_cnt <= '0;
      else if (tick)
        ms_cnt <= ms_cnt + MSW'(1);
    end
  end

endmodule

// File: tb/tb_riego_multicanal.sv
// Directed bench for riego_multicanal (NCH=4 main instance, NCH=5 instance for
// out-of-range channel handling). Tick timing is tracked by counting edges since reset.
module tb_riego_multicanal;

  localparam int unsigned TDIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_valid, fault_clr;
  logic [1:0]  sample_ch;
  logic [11:0] sample_hum;
  logic [3:0]  plant_type;
  logic [3:0]  pump_present, pump_en, fault;
  logic        alarm, busy;

  logic        s5_valid;
  logic [2:0]  s5_ch;
  logic [11:0] s5_hum;
  logic [4:0]  pump5, fault5;
  logic        alarm5, busy5;

  int unsigned ecnt;
  int          nchecks = 0;
  int          nerr = 0;

  riego_multicanal #(.NCH(4), .HUM_W(12), .TICK_DIV(TDIV), .MAX_ON_MS(20),
                     .COOLDOWN_MS(10), .HYST(64)) u_dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_ch(sample_ch),
    .sample_hum(sample_hum), .plant_type(plant_type), .pump_present(pump_present),
    .fault_clr(fault_clr), .pump_en(pump_en), .fault(fault), .alarm(alarm), .busy(busy));

  riego_multicanal #(.NCH(5), .HUM_W(12), .TICK_DIV(TDIV), .MAX_ON_MS(20),
                     .COOLDOWN_MS(10), .HYST(64)) u_dut5 (
    .clk(clk), .rst(rst), .sample_valid(s5_valid), .sample_ch(s5_ch),
    .sample_hum(s5_hum), .plant_type(4'd0), .pump_present(5'h1F),
    .fault_clr(1'b0), .pump_en(pump5), .fault(fault5), .alarm(alarm5), .busy(busy5));

  always #5 clk = ~clk;

  // Edges since the last reset edge; a ms tick lands on edges where this is a multiple of TDIV
  always @(posedge clk) begin
    if (rst) ecnt <= 0;
    else     ecnt <= ecnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int ch, input int hum, input int pt);
    sample_ch    = 2'(ch);
    sample_hum   = 12'(hum);
    plant_type   = 4'(pt);
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  // Wait until n ms ticks have been counted since the last state entry
  task automatic wait_ms(input int n);
    int c = 0;
    while (c < n) begin
      @(negedge clk);
      if (ecnt % TDIV == 0) c++;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; sample_valid = 1'b0; fault_clr = 1'b0; sample_ch = '0;
    sample_hum = '0; plant_type = '0; pump_present = 4'hF;
    s5_valid = 1'b0; s5_ch = '0; s5_hum = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset pump_en", 32'(pump_en), 0);
    chk("reset fault", 32'(fault), 0);
    chk("reset alarm", 32'(alarm), 0);
    chk("reset busy", 32'(busy), 0);

    // Out-of-range channel on the NCH=5 instance is ignored; channel 4 works
    s5_ch = 3'd5; s5_hum = 12'h100; s5_valid = 1'b1;
    @(negedge clk); s5_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("ch5 ignored", 32'(pump5), 0);
    s5_ch = 3'd4; s5_valid = 1'b1;
    @(negedge clk); s5_valid = 1'b0;
    @(negedge clk);
    chk("ch4 granted", 32'(pump5), 32'h10);
    chk("ch4 busy lag", 32'(busy5), 0);
    @(negedge clk);
    chk("ch4 busy", 32'(busy5), 1);

    // Basic run on ch1
    send(1, 'h100, 1);
    chk("t2 not yet", 32'(pump_en), 0);
    @(negedge clk);
    chk("t2 grant", 32'(pump_en), 32'h2);
    send(1, 'h640, 1);
    chk("t2 wet stop", 32'(pump_en), 0);
    wait_ms(10);
    chk("t2 cool busy", 32'(busy), 1);
    @(negedge clk);
    @(negedge clk);
    chk("t2 idle busy", 32'(busy), 0);
    chk("t2 idle pump", 32'(pump_en), 0);

    // Hysteresis on ch2 (start 0x900, stop 0x940)
    send(2, 'h800, 2);
    @(negedge clk);
    chk("t3 grant", 32'(pump_en), 32'h4);
    send(2, 'h920, 2);
    chk("t3 hold", 32'(pump_en), 32'h4);
    send(2, 'h940, 2);
    chk("t3 stop", 32'(pump_en), 0);
    wait_ms(10);
    @(negedge clk);
    @(negedge clk);

    // Timeout on ch0
    send(0, 'h100, 0);
    @(negedge clk);
    chk("t4 grant", 32'(pump_en), 32'h1);
    wait_ms(20);
    chk("t4 on at limit", 32'(pump_en), 32'h1);
    chk("t4 no fault yet", 32'(fault), 0);
    @(negedge clk);
    chk("t4 off", 32'(pump_en), 0);
    chk("t4 fault", 32'(fault), 32'h1);
    wait_ms(10);
    chk("t4 alarm", 32'(alarm), 1);
    repeat (6) @(negedge clk);
    chk("t4 no regrant", 32'(pump_en), 0);

    // Round-robin: rr=0, ch0 and ch3 both eligible -> ch3 first
    fault_clr = 1'b1;
    send(3, 'h100, 5);
    fault_clr = 1'b0;
    chk("t5 fault clr", 32'(fault), 0);
    @(negedge clk);
    chk("t5 ch3 first", 32'(pump_en), 32'h8);
    chk("t5 alarm clr", 32'(alarm), 0);
    send(3, 'h800, 5);
    chk("t5 ch3 stop", 32'(pump_en), 0);
    wait_ms(10);
    @(negedge clk);
    @(negedge clk);
    chk("t5 ch0 next", 32'(pump_en), 32'h1);
    send(0, 'h300, 0);
    chk("t5 ch0 stop", 32'(pump_en), 0);
    wait_ms(10);
    @(negedge clk);
    @(negedge clk);

    // Pump removed mid-run: off without fault
    send(1, 'h100, 1);
    @(negedge clk);
    chk("t6 grant", 32'(pump_en), 32'h2);
    pump_present = 4'b1101;
    @(negedge clk);
    pump_present = 4'hF;
    chk("t6 absent off", 32'(pump_en), 0);
    chk("t6 absent no fault", 32'(fault), 0);
    wait_ms(10);
    @(negedge clk);
    @(negedge clk);
    chk("t6 regrant", 32'(pump_en), 32'h2);

    // Wet sample on the same edge as the timeout: no fault
    wait_ms(20);
    chk("t6 on at limit", 32'(pump_en), 32'h2);
    send(1, 'h700, 1);
    chk("t6 coincide off", 32'(pump_en), 0);
    chk("t6 coincide no fault", 32'(fault), 0);
    wait_ms(10);
    @(negedge clk);
    @(negedge clk);

    // Reset mid-RUN with a fault and alarm pending
    send(2, 'h100, 2);
    @(negedge clk);
    chk("t1 ch2 grant", 32'(pump_en), 32'h4);
    wait_ms(20);
    @(negedge clk);
    chk("t1 ch2 fault", 32'(fault), 32'h4);
    wait_ms(10);
    @(negedge clk);
    @(negedge clk);
    send(3, 'h100, 5);
    @(negedge clk);
    chk("t1 ch3 grant", 32'(pump_en), 32'h8);
    chk("t1 alarm set", 32'(alarm), 1);
    @(negedge clk);
    chk("t1 busy set", 32'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("t1 rst pump", 32'(pump_en), 0);
    chk("t1 rst fault", 32'(fault), 0);
    chk("t1 rst busy", 32'(busy), 0);
    chk("t1 rst alarm", 32'(alarm), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t1 need cleared", 32'(pump_en), 0);
    chk("dut5 no fault", 32'(fault5), 0);
    chk("dut5 no alarm", 32'(alarm5), 0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
